bh_burst_send: RTL and testbench

Parametrised successor of the single-shot Bluetooth key-triggered UART sender. It buffers host-written bytes in an internal FIFO and, on a debounced key press, transmits every byte buffered at that instant as back-to-back UART frames on `uart_txd` toward the Bluetooth module. Frame width, baud divider, buffer depth and debounce time are parameters; an optional even-parity bit is compile-time selectable.

---
 rtl/bh_burst_send.sv | 214 +++++++++++++++++++++
 tb/tb_bh_burst_send.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bh_burst_send.sv
// Key-triggered burst UART sender: host bytes are queued in a FIFO and a debounced
// key press sends every queued byte back-to-back. Optional macro BH_PARITY_EN adds an even-parity bit.
module bh_burst_send #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 434,
  parameter int DEPTH      = 16,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 key,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 uart_txd
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int BCW = $clog2(BAUD_DIV);
  localparam int BIW = $clog2(DATA_BITS);
  localparam int DW  = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef BH_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  logic                 sync1_r, sync2_r, deb_r, deb_d_r, press_r;
  logic [DW-1:0]        deb_cnt_r;
  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_next_s, burst_left_r;
  logic                 full_r, empty_r, push_s, pop_s, tick_s, trigger_s;
  logic                 txd_r, txd_next_s, busy_r;
  state_t               state_r, state_next_s;
  logic [BCW-1:0]       baud_cnt_r;
  logic [BIW-1:0]       bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r, head_s;
`ifdef BH_PARITY_EN
  logic                 par_r;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  // Key synchroniser, debouncer and press-edge pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      deb_r     <= 1'b1;
      deb_d_r   <= 1'b1;
      press_r   <= 1'b0;
      deb_cnt_r <= '0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      press_r <= deb_d_r & ~deb_r;
      if (sync2_r != deb_r) begin
        if (deb_cnt_r == DW'(DEB_CYCLES - 1)) begin
          deb_r     <= sync2_r;
          deb_cnt_r <= '0;
        end else begin
          deb_cnt_r <= deb_cnt_r + DW'(1);
        end
      end else begin
        deb_cnt_r <= '0;
      end
    end
  end

  // FIFO occupancy; flags describe the count after this edge
  always_comb begin
    push_s       = wr_en & ~full_r;
    count_next_s = count_r + CW'(push_s) - CW'(pop_s);
    head_s       = mem_r[rd_ptr_r];
  end

  // FIFO pointers, count and registered flags
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == '0);
    end
  end

  // FIFO storage
  always_ff @(posedge sys_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign tick_s    = (baud_cnt_r == BCW'(BAUD_DIV - 1));
  assign trigger_s = press_r & ~empty_r & (state_r == ST_IDLE);

  // Next state, FIFO pop and the line level for the next cycle
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    txd_next_s   = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          state_next_s = ST_START;
          pop_s        = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) state_next_s = ST_DATA;
        else        state_next_s = ST_START;
      end
      ST_DATA: begin
        if (tick_s && (bit_cnt_r == BIW'(DATA_BITS - 1))) begin
`ifdef BH_PARITY_EN
          state_next_s = ST_PARITY;
`else
          state_next_s = ST_STOP;
`endif
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef BH_PARITY_EN
      ST_PARITY: begin
        if (tick_s) state_next_s = ST_STOP;
        else        state_next_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          if (burst_left_r == CW'(1)) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_START;
            pop_s        = 1'b1;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase

    case (state_next_s)
      ST_START:  txd_next_s = 1'b0;
      ST_DATA:   txd_next_s = (state_r == ST_DATA && tick_s) ? shift_r[1] : shift_r[0];
`ifdef BH_PARITY_EN
      ST_PARITY: txd_next_s = par_r;
`endif
      default:   txd_next_s = 1'b1;
    endcase
  end

  // Frame sequencing: state, baud/bit counters, shifter and burst length
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      baud_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      burst_left_r <= '0;
      txd_r        <= 1'b1;
      busy_r       <= 1'b0;
`ifdef BH_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      txd_r   <= txd_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (state_r == ST_IDLE || tick_s) baud_cnt_r <= '0;
      else                              baud_cnt_r <= baud_cnt_r + BCW'(1);
      if (state_r != ST_DATA) bit_cnt_r <= '0;
      else if (tick_s)        bit_cnt_r <= bit_cnt_r + BIW'(1);
      if (pop_s) begin
        shift_r <= head_s;
`ifdef BH_PARITY_EN
        par_r   <= even_parity(head_s);
`endif
      end else if (state_r == ST_DATA && tick_s) begin
        shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
      end
      // burst length is frozen at trigger; later writes wait for the next press
      if (trigger_s)                          burst_left_r <= count_r;
      else if (state_r == ST_STOP && tick_s)  burst_left_r <= burst_left_r - CW'(1);
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign busy     = busy_r;
  assign uart_txd = txd_r;

endmodule

// File: tb/tb_bh_burst_send.sv
// Directed bench for bh_burst_send: a UART monitor decodes frames and compares them
// against a queue of bytes expected from the writes the bench has made.
module tb_bh_burst_send;

  localparam int DATA_BITS  = 8;
  localparam int BAUD_DIV   = 4;
  localparam int DEPTH      = 4;
  localparam int DEB_CYCLES = 3;
`ifdef BH_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME  = (2 + DATA_BITS + PBITS) * BAUD_DIV;
  localparam int STOP_T = BAUD_DIV * (DATA_BITS + 1 + PBITS) + 2;

  logic       clk = 1'b0;
  logic       sys_rst, key, wr_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, uart_txd;

  int         vectors = 0;
  int         miscompares = 0;
  int         rx_cnt = 0;
  int         model_cnt = 0;
  logic [7:0] exp_q[$];

  bh_burst_send #(
    .DATA_BITS(DATA_BITS), .BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .key(key), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples mid-bit on falling clock edges
  initial begin
    bit         rx_on;
    int         rx_t;
    logic [7:0] rx_byte;
    logic       rx_par;
    logic [7:0] e;
    rx_on = 1'b0; rx_t = 0; rx_byte = 8'h00; rx_par = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst === 1'b1) begin
        rx_on = 1'b0;
      end else if (!rx_on) begin
        if (uart_txd === 1'b0) begin
          rx_on = 1'b1;
          rx_t  = 0;
        end
      end else begin
        rx_t++;
        if (rx_t == 2) check("start_bit", uart_txd, 1'b0);
        if (rx_t >= 6 && rx_t <= BAUD_DIV * DATA_BITS + 2 && ((rx_t - 2) % BAUD_DIV) == 0)
          rx_byte[(rx_t - 6) / BAUD_DIV] = uart_txd;
        if (PBITS == 1 && rx_t == BAUD_DIV * (DATA_BITS + 1) + 2) rx_par = uart_txd;
        if (rx_t == STOP_T) begin
          check("stop_bit", uart_txd, 1'b1);
          if (PBITS == 1) check("parity_bit", rx_par, ^rx_byte);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", rx_byte, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", rx_byte, e);
          end
          rx_cnt++;
          rx_on = 1'b0;
        end
      end
    end
  end

  // Drive one write at the current time (just after a rising edge) and model acceptance
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (model_cnt < DEPTH) begin
      exp_q.push_back(b);
      model_cnt++;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Press, check latency, then time busy; optionally check the last pop and disturb mid-burst
  task automatic send_burst(input int nbytes, input int chk_empty, input bit mid);
    int lat, bl, rx0;
    bit found;
    rx0 = rx_cnt; lat = 0; found = 1'b0;
    @(posedge clk); #1;
    key = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (uart_txd === 1'b0) found = 1'b1;
    end
    check("press_latency", lat, 7);
    key = 1'b1;
    bl = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy !== 1'b1) break;
      bl++;
      if (chk_empty > 1 && bl == chk_empty - 1) check("empty_before_last_pop", empty, 1'b0);
      if (chk_empty > 0 && bl == chk_empty)     check("empty_after_last_pop", empty, 1'b1);
      if (mid && bl == 10) begin
        wr_en = 1'b1; wr_data = 8'h55;
        exp_q.push_back(8'h55); model_cnt++;
      end else begin
        wr_en = 1'b0;
      end
      key = (mid && bl >= 20 && bl < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0; key = 1'b1;
    check("busy_length", bl, nbytes * FRAME);
    check("frames_sent", rx_cnt - rx0, nbytes);
    model_cnt -= nbytes;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    bit seen;
    bit found;
    int rx0;
    sys_rst = 1'b1; key = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    sys_rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // press with nothing queued
    key = 1'b0; seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy === 1'b1 || uart_txd === 1'b0) seen = 1'b1;
      if (i == 10) key = 1'b1;
    end
    check("empty_press_idle", seen, 1'b0);

    // single byte
    @(posedge clk); #1;
    write_byte(8'hA5);
    check("one_entry_empty", empty, 1'b0);
    send_burst(1, 0, 1'b0);

    // three-byte burst
    @(posedge clk); #1;
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
    send_burst(3, 2 * FRAME + 1, 1'b0);
    check("empty_after_burst", empty, 1'b1);

    // overfill
    @(posedge clk); #1;
    write_byte(8'h10); write_byte(8'h11); write_byte(8'h12);
    check("full_after_3", full, 1'b0);
    write_byte(8'h13);
    check("full_after_4", full, 1'b1);
    write_byte(8'h14);
    check("full_after_drop", full, 1'b1);
    send_burst(4, 3 * FRAME + 1, 1'b0);
    check("full_cleared", full, 1'b0);

    // bouncing key with one byte queued
    @(posedge clk); #1;
    write_byte(8'h3C);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20) key = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else        key = 1'b1;
      @(posedge clk); #1;
      if (busy === 1'b1 || uart_txd === 1'b0) seen = 1'b1;
    end
    check("bounce_no_tx", seen, 1'b0);
    check("bounce_still_queued", empty, 1'b0);
    send_burst(1, 0, 1'b0);

    // mid-burst write and second press
    @(posedge clk); #1;
    write_byte(8'h11); write_byte(8'h22);
    send_burst(2, 0, 1'b1);
    check("mid_write_queued", empty, 1'b0);
    send_burst(1, 0, 1'b0);

    // reset during a data bit
    @(posedge clk); #1;
    write_byte(8'h77); write_byte(8'h88);
    rx0 = rx_cnt; found = 1'b0;
    key = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1'b1;
    end
    check("rst_burst_started", found, 1'b1);
    repeat (10) @(negedge clk);
    sys_rst = 1'b1; key = 1'b1;
    @(posedge clk); #1;
    check("midrst_txd", uart_txd, 1'b1);
    check("midrst_empty", empty, 1'b1);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    sys_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy === 1'b1 || uart_txd === 1'b0) seen = 1'b1;
    end
    check("after_rst_quiet", seen, 1'b0);
    check("after_rst_no_frame", rx_cnt - rx0, 0);

    check("all_expected_sent", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
